// File: rtl/bcd_hex_display.sv
// bcd_hex_display
//   Converts a binary value to three decimal digits with a serial double-dabble
//   conversion (one input bit per clock). It drives three active-low 7-segment
//   displays with leading-zero blanking and shows "EEE" for values above
//   MAX_VALUE. A one-deep pending buffer holds a value loaded while a conversion
//   is running, so back-to-back loads chain with no idle gap.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   value  : binary value to display (WIDTH bits)
//   load   : one-cycle strobe; value is sampled on the same edge
//   HEX0   : ones digit, active-low, bit order g..a
//   HEX1   : tens digit, active-low
//   HEX2   : hundreds digit, active-low
//   busy   : a conversion is in progress
//   done   : one-cycle pulse on the cycle the HEX outputs update
module bcd_hex_display #(
    parameter int WIDTH     = 8,
    parameter int MAX_VALUE = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic             busy,
    output logic             done
);

    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_E     = 7'b0000110;
    localparam logic [31:0] MAX_W     = 32'(MAX_VALUE);
    localparam logic [3:0]  CNT_INIT  = 4'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_t           state;
    logic [WIDTH-1:0] sr;        // binary bits still to be shifted in, MSB first
    logic [WIDTH-1:0] val_lat;   // value being converted, kept for the range check
    logic [WIDTH-1:0] pend_val;
    logic             pend_vld;
    logic [11:0]      bcd;
    logic [11:0]      bcd_adj;
    logic [11:0]      bcd_next;
    logic [3:0]       cnt;
    logic [6:0]       hex0_n, hex1_n, hex2_n;
    logic             out_of_range;
    logic [WIDTH-1:0] next_val;

    // Double-dabble step: correct every nibble >= 5, then shift in the next bit.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_next    = bcd_adj << 1;
        bcd_next[0] = sr[WIDTH-1];
    end

    always_comb begin
        out_of_range = 32'(val_lat) > MAX_W;
        if (out_of_range) begin
            hex2_n = SEG_E;
            hex1_n = SEG_E;
            hex0_n = SEG_E;
        end else begin
            hex2_n = (bcd[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd[11:8]);
            hex1_n = (bcd[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd[7:4]);
            hex0_n = seg7(bcd[3:0]);
        end
    end

    // A load arriving in the UPDATE cycle is the newest value, so it wins over
    // whatever is already pending and is started immediately.
    assign next_val = load ? value : pend_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            pend_vld <= 1'b0;
            cnt      <= 4'd0;
            HEX0     <= SEG_BLANK;
            HEX1     <= SEG_BLANK;
            HEX2     <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        sr      <= value;
                        val_lat <= value;
                        bcd     <= 12'd0;
                        cnt     <= CNT_INIT;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (load) begin
                        pend_val <= value;
                        pend_vld <= 1'b1;
                    end
                    bcd <= bcd_next;
                    sr  <= sr << 1;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= UPDATE;
                end
                UPDATE: begin
                    HEX0 <= hex0_n;
                    HEX1 <= hex1_n;
                    HEX2 <= hex2_n;
                    done <= 1'b1;
                    if (load || pend_vld) begin
                        sr       <= next_val;
                        val_lat  <= next_val;
                        bcd      <= 12'd0;
                        cnt      <= CNT_INIT;
                        pend_vld <= 1'b0;
                        state    <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_hex_display.sv
module tb_bcd_hex_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SE = 7'b0000110;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] value = 8'd0, value2 = 8'd0;
    logic       load = 1'b0, load2 = 1'b0;
    logic [6:0] hex0, hex1, hex2, h2_0, h2_1, h2_2;
    logic       busy, done, busy2, done2;

    int n_vec = 0;
    int n_err = 0;

    bcd_hex_display #(.WIDTH(8), .MAX_VALUE(255)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .busy(busy), .done(done)
    );

    bcd_hex_display #(.WIDTH(8), .MAX_VALUE(200)) dut200 (
        .clk(clk), .reset(reset), .value(value2), .load(load2),
        .HEX0(h2_0), .HEX1(h2_1), .HEX2(h2_2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int seen;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || done2) seen++;
        end
        n_vec++;
        if ({hex2, hex1, hex0} !== {SB, SB, SB}) begin
            n_err++;
            $display("FAIL reset_hex got %b %b %b want all 1111111", hex2, hex1, hex0);
        end
        n_vec++;
        if ({h2_2, h2_1, h2_0} !== {SB, SB, SB}) begin
            n_err++;
            $display("FAIL reset_hex_dut200 got %b %b %b want all 1111111", h2_2, h2_1, h2_0);
        end
        n_vec++;
        if (busy !== 1'b0 || busy2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy got %b/%b want 0/0", busy, busy2);
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_done_idle got %0d pulses want 0", seen);
        end
    endtask

    task automatic test_zero();
        int n;
        value = 8'd0;
        load  = 1'b1;
        tick();
        load = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL zero_busy_start got %b want 1", busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_vec++;
        if (n !== 9) begin
            n_err++;
            $display("FAIL zero_latency got %0d want 9", n);
        end
        n_vec++;
        if ({hex2, hex1, hex0} !== {SB, SB, S0}) begin
            n_err++;
            $display("FAIL zero_hex got %b %b %b want %b %b %b", hex2, hex1, hex0, SB, SB, S0);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_busy_at_done got %b want 0", busy);
        end
        tick();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL zero_done_pulse_width got %b want 0", done);
        end
    endtask

    task automatic test_values();
        logic [7:0]  vals [7];
        logic [20:0] exp  [7];
        logic [20:0] prev;
        int n;
        bit moved;
        vals = '{8'd233, 8'd144, 8'd105, 8'd7, 8'd60, 8'd89, 8'd255};
        exp  = '{{S2, S3, S3}, {S1, S4, S4}, {S1, S0, S5}, {SB, SB, S7},
                 {SB, S6, S0}, {SB, S8, S9}, {S2, S5, S5}};
        prev = {SB, SB, S0};
        for (int i = 0; i < 7; i++) begin
            value = vals[i];
            load  = 1'b1;
            tick();
            load  = 1'b0;
            n     = 0;
            moved = 1'b0;
            while (done !== 1'b1 && n < 20) begin
                if ({hex2, hex1, hex0} !== prev) moved = 1'b1;
                tick();
                n++;
            end
            n_vec++;
            if (n !== 9 || moved) begin
                n_err++;
                $display("FAIL value_%0d_timing latency %0d want 9, early_change %0b want 0",
                         vals[i], n, moved);
            end
            n_vec++;
            if ({hex2, hex1, hex0} !== exp[i]) begin
                n_err++;
                $display("FAIL value_%0d_hex got %b %b %b want %b %b %b", vals[i],
                         hex2, hex1, hex0, exp[i][20:14], exp[i][13:7], exp[i][6:0]);
            end
            prev = exp[i];
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, pulses;
        bit gap;
        logic [20:0] h1, h2v;
        t1 = -1; t2 = -1; pulses = 0; gap = 1'b0;
        h1 = '0; h2v = '0;
        value = 8'd144;
        load  = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            load  = (c == 2) || (c == 6);
            value = (c == 2) ? 8'd89 : 8'd55;
            tick();
            load = 1'b0;
            if (c < 18 && busy !== 1'b1) gap = 1'b1;
            if (done) begin
                pulses++;
                if (t1 < 0) begin
                    t1 = c; h1 = {hex2, hex1, hex0};
                end else if (t2 < 0) begin
                    t2 = c; h2v = {hex2, hex1, hex0};
                end
            end
        end
        n_vec++;
        if (t1 !== 9 || h1 !== {S1, S4, S4}) begin
            n_err++;
            $display("FAIL b2b_first got t=%0d hex=%b want t=9 hex=%b", t1, h1, {S1, S4, S4});
        end
        n_vec++;
        if (t2 !== 18 || h2v !== {SB, S5, S5}) begin
            n_err++;
            $display("FAIL b2b_second got t=%0d hex=%b want t=18 hex=%b", t2, h2v, {SB, S5, S5});
        end
        n_vec++;
        if (pulses !== 2 || gap) begin
            n_err++;
            $display("FAIL b2b_pulses got %0d pulses gap=%0b want 2 pulses gap=0", pulses, gap);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_busy_end got %b want 0", busy);
        end
    endtask

    task automatic test_range();
        logic [7:0]  vals [2];
        logic [20:0] exp  [2];
        int n;
        vals = '{8'd201, 8'd200};
        exp  = '{{SE, SE, SE}, {S2, S0, S0}};
        for (int i = 0; i < 2; i++) begin
            value2 = vals[i];
            load2  = 1'b1;
            tick();
            load2 = 1'b0;
            n = 0;
            while (done2 !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            n_vec++;
            if (n !== 9 || {h2_2, h2_1, h2_0} !== exp[i]) begin
                n_err++;
                $display("FAIL range_%0d got t=%0d hex=%b want t=9 hex=%b", vals[i], n,
                         {h2_2, h2_1, h2_0}, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        bit bad;
        value = 8'd233;
        load  = 1'b1;
        tick();
        load = 1'b0;
        tick();
        value = 8'd77;
        load  = 1'b1;
        tick();
        load = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        seen = 0; bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) seen++;
            if (busy !== 1'b0 || {hex2, hex1, hex0} !== {SB, SB, SB}) bad = 1'b1;
        end
        n_vec++;
        if (seen !== 0 || bad) begin
            n_err++;
            $display("FAIL abort got %0d done pulses, nonblank_or_busy=%0b want 0/0", seen, bad);
        end
        // load coinciding with reset must be dropped
        value = 8'd5;
        load  = 1'b1;
        reset = 1'b1;
        tick();
        load  = 1'b0;
        reset = 1'b0;
        seen = 0; bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) seen++;
            if (busy !== 1'b0) bad = 1'b1;
        end
        n_vec++;
        if (seen !== 0 || bad || {hex2, hex1, hex0} !== {SB, SB, SB}) begin
            n_err++;
            $display("FAIL load_with_reset got %0d pulses busy_seen=%0b hex=%b want 0/0/all blank",
                     seen, bad, {hex2, hex1, hex0});
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_zero();
        test_values();
        test_back_to_back();
        test_range();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
